// File: rtl/toggle_port_responder.sv
// Toggle req/ack memory responder backed by on-chip dual-port RAM, plus a registered CPU read port.
// Optional macro TOGGLE_PORT_BYPASS_EN forwards a same-edge port1 write to the CPU read.
module toggle_port_responder #(
    parameter int unsigned AW     = 15,
    parameter int unsigned WR_LAT = 2
) (
    input  logic          clock_48,
    input  logic          reset,
    input  logic          port1_req,
    output logic          port1_ack,
    input  logic [AW-1:0] port1_a,
    input  logic [1:0]    port1_ds,
    input  logic          port1_we,
    input  logic [15:0]   port1_d,
    output logic [15:0]   port1_q,
    input  logic          cpu_oe,
    input  logic [AW-1:0] cpu_addr,
    output logic [15:0]   cpu_q,
    output logic          busy
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   hold_a;
    logic [1:0]      hold_ds;
    logic            hold_we;
    logic [15:0]     hold_d;

    logic [7:0]      mem_hi [DEPTH];
    logic [7:0]      mem_lo [DEPTH];

    logic            commit_c;
    logic [15:0]     ram_word_c;
    logic [15:0]     cpu_rd_c;

    // A write commits on the last ACCESS cycle; reset forces IDLE so a pending write is dropped.
    assign commit_c   = (state == ACCESS) && (cnt == '0) && hold_we;
    assign ram_word_c = {mem_hi[hold_a], mem_lo[hold_a]};

    always_ff @(posedge clock_48) begin
        if (commit_c && hold_ds[1]) mem_hi[hold_a] <= hold_d[15:8];
        if (commit_c && hold_ds[0]) mem_lo[hold_a] <= hold_d[7:0];
    end

`ifdef TOGGLE_PORT_BYPASS_EN
    // Merge the committing write into a same-address CPU read, lane by lane.
    always_comb begin
        cpu_rd_c = {mem_hi[cpu_addr], mem_lo[cpu_addr]};
        if (commit_c && (hold_a == cpu_addr)) begin
            if (hold_ds[1]) cpu_rd_c[15:8] = hold_d[15:8];
            if (hold_ds[0]) cpu_rd_c[7:0]  = hold_d[7:0];
        end
    end
`else
    assign cpu_rd_c = {mem_hi[cpu_addr], mem_lo[cpu_addr]};
`endif

    always_ff @(posedge clock_48 or posedge reset) begin
        if (reset) begin
            cpu_q <= '0;
        end else if (cpu_oe) begin
            cpu_q <= cpu_rd_c;
        end
    end

    // Transaction sequencer: capture, emulated latency, then acknowledge.
    always_ff @(posedge clock_48 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            port1_ack <= 1'b0;
            port1_q   <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            hold_a    <= '0;
            hold_ds   <= '0;
            hold_we   <= 1'b0;
            hold_d    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (port1_req != port1_ack) begin
                        hold_a  <= port1_a;
                        hold_ds <= port1_ds;
                        hold_we <= port1_we;
                        hold_d  <= port1_d;
                        cnt     <= CW'(WR_LAT - 1);
                        busy    <= 1'b1;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (!hold_we) port1_q <= ram_word_c;
                        state <= DONE;
                    end
                end
                DONE: begin
                    port1_ack <= ~port1_ack;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/toggle_port_responder.md
Name: toggle_port_responder

Overview:
- Responder end of the toggle req/ack memory port that the ROM download path drives: port1_req toggles once per transaction, and this block toggles port1_ack when the transaction completes.
- Backs the port with on-chip dual-port RAM, for small cores and simulation builds that do not use SDRAM.
- Also provides a free-running, registered CPU ROM read port.
- Sits between data_io/download logic and the core's roms_addr/roms_do path.

Parameters:
- AW, 15, word-address width; memory depth is 2**AW 16-bit words.
- WR_LAT, 2, emulated access latency in cycles (legal range 1..15); sets the time from request capture to commit.

Ports:
- clock_48  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- port1_req  input  1  request toggle; a transaction is pending when port1_req != port1_ack.
- port1_ack  output  1  acknowledge toggle.
- port1_a  input  AW  word address.
- port1_ds  input  2  byte strobes: [1]=d[15:8], [0]=d[7:0].
- port1_we  input  1  1=write, 0=read.
- port1_d  input  16  write data.
- port1_q  output  16  read data; valid when port1_ack toggles.
- cpu_oe  input  1  CPU read enable.
- cpu_addr  input  AW  CPU word address.
- cpu_q  output  16  CPU read data.
- busy  output  1  high while a port1 transaction is in flight.

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; port1_ack=0, port1_q=0, cpu_q=0, busy=0; latency counter=0.
  - RAM contents are not cleared.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If port1_req != port1_ack, capture a/ds/we/d into holding registers.
  - Load counter=WR_LAT-1, set busy=1, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Decrement counter while it is nonzero.
  - At zero:
    - Write: write each byte lane whose ds bit is 1; lanes with ds=0 are unchanged. ds=00 writes nothing but still completes.
    - Read: load port1_q with RAM[captured a] (full word, ds ignored).
  - Go to DONE.
- DONE: toggle port1_ack, clear busy, go to IDLE.
- Latency: with req toggled before edge N, ack toggles at edge N+WR_LAT+1. The earliest next capture is edge N+WR_LAT+2.
- Captured fields are used, so inputs may change after capture.
- req toggles while busy are not observed until IDLE.
  - Two toggles while busy (protocol violation) leave req==ack, so no extra transaction.
  - One toggle while busy is serviced after return to IDLE.
- CPU port:
  - If cpu_oe=1 at an edge, cpu_q <= RAM[cpu_addr]; 1-cycle latency.
  - If cpu_oe=0, cpu_q holds.
  - Never stalled by port1.
- Collision: a CPU read at the same edge as a port1 write commit to the same address returns the pre-write data (read-before-write).
- Reset mid-transaction:
  - Any uncommitted write is dropped; ack returns to 0.
  - If port1_req=1 after reset, a transaction starts immediately. The initiator must reset its req with the same reset.

Optional Feature:
- Macro: TOGGLE_PORT_BYPASS_EN.
- Defined: on a same-edge, same-address collision, cpu_q returns the new data merged per ds (written lanes new, unwritten lanes old).
- Undefined: read-before-write as above; no forwarding mux is generated.

Test Plan:
- Reset, then write a=0x0123, d=0xBEEF, ds=11, toggle req 0->1 → busy=1 next edge; ack 0->1 exactly WR_LAT+1 edges after capture; then cpu_oe=1, cpu_addr=0x0123 → cpu_q=0xBEEF one cycle later.
- Byte-lane writes: write 0x1234 ds=11 to 0x10, then 0xAB55 ds=01 → cpu_q=0x1255; then 0xCDxx ds=10 → 0xCD55; then ds=00 → ack still toggles, data unchanged.
- Port1 read of 0x10 (we=0) → port1_q=0xCD55 at the ack toggle; cpu_q unaffected.
- Stream 256 bytes downloaded as alternating ds=01/10 writes to consecutive addresses, one toggle per ack → all words correct, no lost or duplicate transactions; double toggle while busy → no extra ack.
- Collision: cpu_oe=1 on 0x20 (old 0x0000) at the commit edge of write 0xFFFF ds=11 → cpu_q=0x0000 without the macro, 0xFFFF with TOGGLE_PORT_BYPASS_EN; ds=01 with the macro → 0x00FF.
- Assert reset during ACCESS of write 0x5555 → ack=0, busy=0 immediately, RAM unchanged; with req held at 1 after release, a new transaction completes and ack=1.
